// File: rtl/pipe_ctrl_unit_if.sv
// Control-path bundle between the ID/EX/MEM/WB datapath and pipe_ctrl_unit.
// The master side drives the ID-stage instruction fields and the EX redirect; the slave side returns the stage controls.
interface pipe_ctrl_unit_if #(
    parameter int unsigned RA_W = 5
);
    // ID-stage instruction fields and the EX-resolved redirect
    logic            id_valid;
    logic [6:0]      id_opcode;
    logic [RA_W-1:0] id_rs1;
    logic [RA_W-1:0] id_rs2;
    logic [RA_W-1:0] id_rd;
    logic            ex_redirect;

    // ID/EX controls
    logic            ex_valid;
    logic            ex_alusrc;
    logic            ex_branch;
    logic            ex_jalrsel;
    logic            ex_illegal;
    logic [1:0]      ex_aluop;
    logic [RA_W-1:0] ex_rd;

    // EX/MEM controls
    logic            mem_valid;
    logic            mem_memread;
    logic            mem_memwrite;
    logic [RA_W-1:0] mem_rd;

    // MEM/WB controls
    logic            wb_valid;
    logic            wb_regwrite;
    logic            wb_memtoreg;
    logic [1:0]      wb_rwsel;
    logic [RA_W-1:0] wb_rd;

    // Front-end hazard controls and sticky status
    logic            pc_stall;
    logic            ifid_stall;
    logic            ifid_flush;
    logic            illegal_seen;

    modport master (
        output id_valid, id_opcode, id_rs1, id_rs2, id_rd, ex_redirect,
        input  ex_valid, ex_alusrc, ex_branch, ex_jalrsel, ex_illegal, ex_aluop, ex_rd,
        input  mem_valid, mem_memread, mem_memwrite, mem_rd,
        input  wb_valid, wb_regwrite, wb_memtoreg, wb_rwsel, wb_rd,
        input  pc_stall, ifid_stall, ifid_flush, illegal_seen
    );

    modport slave (
        input  id_valid, id_opcode, id_rs1, id_rs2, id_rd, ex_redirect,
        output ex_valid, ex_alusrc, ex_branch, ex_jalrsel, ex_illegal, ex_aluop, ex_rd,
        output mem_valid, mem_memread, mem_memwrite, mem_rd,
        output wb_valid, wb_regwrite, wb_memtoreg, wb_rwsel, wb_rd,
        output pc_stall, ifid_stall, ifid_flush, illegal_seen
    );
endinterface

// File: rtl/pipe_ctrl_unit.sv
// RV32I main control: ID decode carried through ID/EX, EX/MEM, MEM/WB (+1/+2/+3 cycles); no back-pressure downstream.
// Load-use inserts one EX bubble and holds PC/IF-ID; an EX redirect flushes IF/ID and bubbles ID/EX, taking priority.
module pipe_ctrl_unit #(
    parameter int unsigned RA_W           = 5,
    parameter bit          LOAD_USE_STALL = 1'b1,
    parameter bit          X0_WRITE_MASK  = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    pipe_ctrl_unit_if.slave bus
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef struct packed {
        logic            valid;
        logic            illegal;
        logic            alusrc;
        logic            memtoreg;
        logic            regwrite;
        logic            memread;
        logic            memwrite;
        logic [1:0]      aluop;
        logic            branch;
        logic            jalrsel;
        logic [1:0]      rwsel;
        logic [RA_W-1:0] rd;
    } idex_t;

    typedef struct packed {
        logic            valid;
        logic            memtoreg;
        logic            regwrite;
        logic            memread;
        logic            memwrite;
        logic [1:0]      rwsel;
        logic [RA_W-1:0] rd;
    } exmem_t;

    typedef struct packed {
        logic            valid;
        logic            memtoreg;
        logic            regwrite;
        logic [1:0]      rwsel;
        logic [RA_W-1:0] rd;
    } memwb_t;

    idex_t  dec;
    idex_t  idex_d,  idex_q;
    exmem_t exmem_d, exmem_q;
    memwb_t memwb_d, memwb_q;
    logic   seen_d,  seen_q;

    logic   rs1_used;
    logic   rs2_used;
    logic   rs1_hit;
    logic   rs2_hit;
    logic   load_use_raw;
    logic   load_use;
    logic   redirect;

    // ID decode; rd and valid travel with the slot even when the opcode decodes to nothing
    always_comb begin
        dec       = '0;
        rs1_used  = 1'b0;
        rs2_used  = 1'b0;
        dec.valid = bus.id_valid;
        dec.rd    = bus.id_rd;
        if (bus.id_valid) begin
            unique case (bus.id_opcode)
                OP_R: begin
                    dec.regwrite = 1'b1;
                    dec.aluop    = 2'b10;
                    rs1_used     = 1'b1;
                    rs2_used     = 1'b1;
                end
                OP_IALU: begin
                    dec.alusrc   = 1'b1;
                    dec.regwrite = 1'b1;
                    dec.aluop    = 2'b10;
                    rs1_used     = 1'b1;
                end
                OP_LOAD: begin
                    dec.alusrc   = 1'b1;
                    dec.memtoreg = 1'b1;
                    dec.regwrite = 1'b1;
                    dec.memread  = 1'b1;
                    rs1_used     = 1'b1;
                end
                OP_STORE: begin
                    dec.alusrc   = 1'b1;
                    dec.memwrite = 1'b1;
                    rs1_used     = 1'b1;
                    rs2_used     = 1'b1;
                end
                OP_BRANCH: begin
                    dec.aluop    = 2'b01;
                    dec.branch   = 1'b1;
                    rs1_used     = 1'b1;
                    rs2_used     = 1'b1;
                end
                OP_JAL: begin
                    dec.regwrite = 1'b1;
                    dec.aluop    = 2'b11;
                    dec.branch   = 1'b1;
                    dec.rwsel    = 2'b01;
                end
                OP_JALR: begin
                    dec.alusrc   = 1'b1;
                    dec.regwrite = 1'b1;
                    dec.jalrsel  = 1'b1;
                    dec.rwsel    = 2'b01;
                    rs1_used     = 1'b1;
                end
                OP_LUI: begin
                    dec.regwrite = 1'b1;
                    dec.aluop    = 2'b11;
                    dec.rwsel    = 2'b10;
                end
                OP_AUIPC: begin
                    dec.regwrite = 1'b1;
                    dec.rwsel    = 2'b11;
                end
                default: begin
                    dec.illegal  = 1'b1;
                end
            endcase
        end
    end

    // A load in EX whose rd (never x0) feeds a source actually read by the ID instruction
    assign rs1_hit      = rs1_used & (bus.id_rs1 == idex_q.rd);
    assign rs2_hit      = rs2_used & (bus.id_rs2 == idex_q.rd);
    assign load_use_raw = idex_q.valid & idex_q.memread & (idex_q.rd != '0) &
                          bus.id_valid & (rs1_hit | rs2_hit);
    assign load_use     = LOAD_USE_STALL & load_use_raw;
    assign redirect     = bus.ex_redirect & idex_q.valid;

    always_comb begin
        idex_d = dec;
        if (redirect || load_use) begin
            idex_d = '0;
        end
    end

    always_comb begin
        exmem_d          = '0;
        exmem_d.valid    = idex_q.valid;
        exmem_d.memtoreg = idex_q.memtoreg;
        exmem_d.regwrite = idex_q.regwrite;
        exmem_d.memread  = idex_q.memread;
        exmem_d.memwrite = idex_q.memwrite;
        exmem_d.rwsel    = idex_q.rwsel;
        exmem_d.rd       = idex_q.rd;
    end

    always_comb begin
        memwb_d          = '0;
        memwb_d.valid    = exmem_q.valid;
        memwb_d.memtoreg = exmem_q.memtoreg;
        memwb_d.regwrite = exmem_q.regwrite;
        memwb_d.rwsel    = exmem_q.rwsel;
        memwb_d.rd       = exmem_q.rd;
    end

    assign seen_d = seen_q | idex_q.illegal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex_q  <= '0;
            exmem_q <= '0;
            memwb_q <= '0;
            seen_q  <= 1'b0;
        end else begin
            idex_q  <= idex_d;
            exmem_q <= exmem_d;
            memwb_q <= memwb_d;
            seen_q  <= seen_d;
        end
    end

    assign bus.ifid_flush   = redirect;
    assign bus.pc_stall     = load_use & ~redirect;
    assign bus.ifid_stall   = load_use & ~redirect;

    assign bus.ex_valid     = idex_q.valid;
    assign bus.ex_alusrc    = idex_q.alusrc;
    assign bus.ex_branch    = idex_q.branch;
    assign bus.ex_jalrsel   = idex_q.jalrsel;
    assign bus.ex_illegal   = idex_q.illegal;
    assign bus.ex_aluop     = idex_q.aluop;
    assign bus.ex_rd        = idex_q.rd;

    assign bus.mem_valid    = exmem_q.valid;
    assign bus.mem_memread  = exmem_q.memread;
    assign bus.mem_memwrite = exmem_q.memwrite;
    assign bus.mem_rd       = exmem_q.rd;

    // Writes to x0 are dropped here so the register file never needs its own guard
    assign bus.wb_valid     = memwb_q.valid;
    assign bus.wb_regwrite  = memwb_q.regwrite & ~(X0_WRITE_MASK & (memwb_q.rd == '0));
    assign bus.wb_memtoreg  = memwb_q.memtoreg;
    assign bus.wb_rwsel     = memwb_q.rwsel;
    assign bus.wb_rd        = memwb_q.rd;

    // Visible in the same cycle the illegal op sits in EX, then held by seen_q
    assign bus.illegal_seen = seen_q | idex_q.illegal;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench for pipe_ctrl_unit: a slot-based pipeline model checked every negedge, plus literal spot checks.
module tb_pipe_ctrl_unit;

    localparam int unsigned RA_W    = 5;
    localparam bit          LU_EN   = 1'b1;
    localparam bit          X0_MASK = 1'b1;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BR     = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_BAD    = 7'b1111111;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    pipe_ctrl_unit_if #(.RA_W(RA_W)) bus ();

    pipe_ctrl_unit #(
        .RA_W          (RA_W),
        .LOAD_USE_STALL(LU_EN),
        .X0_WRITE_MASK (X0_MASK)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // f = {ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, ALUOp[1:0], Branch, JalrSel, RWSel[1:0]}
    typedef struct packed {
        bit        valid;
        bit        illegal;
        bit [10:0] f;
        bit [4:0]  rd;
    } rec_t;

    rec_t m_ex, m_mem, m_wb;
    bit   m_seen;
    bit   m_redir, m_lu;
    bit   c_redir, c_lu;

    function automatic rec_t decode(input logic v, input logic [6:0] op, input logic [4:0] rd);
        rec_t r;
        r       = '0;
        r.valid = v;
        r.rd    = rd;
        if (v) begin
            case (op)
                OP_R:     r.f = 11'b0_0_1_0_0_10_0_0_00;
                OP_I:     r.f = 11'b1_0_1_0_0_10_0_0_00;
                OP_LOAD:  r.f = 11'b1_1_1_1_0_00_0_0_00;
                OP_STORE: r.f = 11'b1_0_0_0_1_00_0_0_00;
                OP_BR:    r.f = 11'b0_0_0_0_0_01_1_0_00;
                OP_JAL:   r.f = 11'b0_0_1_0_0_11_1_0_01;
                OP_JALR:  r.f = 11'b1_0_1_0_0_00_0_1_01;
                OP_LUI:   r.f = 11'b0_0_1_0_0_11_0_0_10;
                OP_AUIPC: r.f = 11'b0_0_1_0_0_00_0_0_11;
                default:  r.illegal = 1'b1;
            endcase
        end
        return r;
    endfunction

    function automatic bit uses_rs1(input logic [6:0] op);
        return op inside {OP_R, OP_I, OP_LOAD, OP_STORE, OP_BR, OP_JALR};
    endfunction

    function automatic bit uses_rs2(input logic [6:0] op);
        return op inside {OP_R, OP_STORE, OP_BR};
    endfunction

    function automatic bit exp_load_use();
        bit hit;
        hit = (uses_rs1(bus.id_opcode) && (bus.id_rs1 == m_ex.rd)) ||
              (uses_rs2(bus.id_opcode) && (bus.id_rs2 == m_ex.rd));
        return LU_EN && m_ex.valid && m_ex.f[7] && (m_ex.rd != 5'd0) && (bus.id_valid === 1'b1) && hit;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: three instruction slots advancing each cycle, bubble injected on redirect or load-use
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ex   = '0;
            m_mem  = '0;
            m_wb   = '0;
            m_seen = 1'b0;
        end else begin
            m_redir = (bus.ex_redirect === 1'b1) && m_ex.valid;
            m_lu    = exp_load_use();
            m_seen  = m_seen | m_ex.illegal;
            m_wb    = m_mem;
            m_mem   = m_ex;
            if (m_redir || m_lu) m_ex = '0;
            else                 m_ex = decode(bus.id_valid, bus.id_opcode, bus.id_rd);
        end
    end

    always @(negedge clk) begin
        c_redir = (bus.ex_redirect === 1'b1) && m_ex.valid;
        c_lu    = exp_load_use() && !c_redir;
        chk("ifid_flush",   32'(bus.ifid_flush),   32'(c_redir));
        chk("pc_stall",     32'(bus.pc_stall),     32'(c_lu));
        chk("ifid_stall",   32'(bus.ifid_stall),   32'(c_lu));
        chk("ex_valid",     32'(bus.ex_valid),     32'(m_ex.valid));
        chk("ex_illegal",   32'(bus.ex_illegal),   32'(m_ex.illegal));
        chk("ex_alusrc",    32'(bus.ex_alusrc),    32'(m_ex.f[10]));
        chk("ex_aluop",     32'(bus.ex_aluop),     32'(m_ex.f[5:4]));
        chk("ex_branch",    32'(bus.ex_branch),    32'(m_ex.f[3]));
        chk("ex_jalrsel",   32'(bus.ex_jalrsel),   32'(m_ex.f[2]));
        chk("ex_rd",        32'(bus.ex_rd),        32'(m_ex.rd));
        chk("mem_valid",    32'(bus.mem_valid),    32'(m_mem.valid));
        chk("mem_memread",  32'(bus.mem_memread),  32'(m_mem.f[7]));
        chk("mem_memwrite", 32'(bus.mem_memwrite), 32'(m_mem.f[6]));
        chk("mem_rd",       32'(bus.mem_rd),       32'(m_mem.rd));
        chk("wb_valid",     32'(bus.wb_valid),     32'(m_wb.valid));
        chk("wb_regwrite",  32'(bus.wb_regwrite),  32'(m_wb.f[8] && !(X0_MASK && m_wb.rd == 5'd0)));
        chk("wb_memtoreg",  32'(bus.wb_memtoreg),  32'(m_wb.f[9]));
        chk("wb_rwsel",     32'(bus.wb_rwsel),     32'(m_wb.f[1:0]));
        chk("wb_rd",        32'(bus.wb_rd),        32'(m_wb.rd));
        chk("illegal_seen", 32'(bus.illegal_seen), 32'(m_seen | m_ex.illegal));
    end

    // Drive one ID-stage slot 1 time unit after the edge, leaving room for spot checks before negedge
    task automatic issue(input logic v, input logic [6:0] op, input logic [4:0] r1,
                         input logic [4:0] r2, input logic [4:0] rd, input logic redir);
        @(posedge clk);
        #1;
        bus.id_valid    = v;
        bus.id_opcode   = op;
        bus.id_rs1      = r1;
        bus.id_rs2      = r2;
        bus.id_rd       = rd;
        bus.ex_redirect = redir;
        #1;
    endtask

    task automatic idle();
        issue(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    endtask

    initial begin
        bus.id_valid    = 1'b0;
        bus.id_opcode   = 7'd0;
        bus.id_rs1      = 5'd0;
        bus.id_rs2      = 5'd0;
        bus.id_rd       = 5'd0;
        bus.ex_redirect = 1'b0;

        // Reset state
        idle(); idle();
        chk("rst_ex_valid",     32'(bus.ex_valid),     32'd0);
        chk("rst_wb_valid",     32'(bus.wb_valid),     32'd0);
        chk("rst_illegal_seen", 32'(bus.illegal_seen), 32'd0);
        rst_n = 1'b1;

        // Load-use: lw x5 ; add x6,x5,x1 held one extra cycle in ID
        issue(1'b1, OP_LOAD, 5'd1, 5'd0, 5'd5, 1'b0);
        issue(1'b1, OP_R, 5'd5, 5'd1, 5'd6, 1'b0);
        chk("lu_pc_stall",   32'(bus.pc_stall),   32'd1);
        chk("lu_ifid_stall", 32'(bus.ifid_stall), 32'd1);
        issue(1'b1, OP_R, 5'd5, 5'd1, 5'd6, 1'b0);
        chk("lu_bubble_ex_valid", 32'(bus.ex_valid), 32'd0);
        chk("lu_released",        32'(bus.pc_stall), 32'd0);
        idle();
        chk("lu_add_ex_valid", 32'(bus.ex_valid), 32'd1);
        chk("lu_add_ex_rd",    32'(bus.ex_rd),    32'd6);
        chk("lu_lw_wb_m2r",    32'(bus.wb_memtoreg), 32'd1);
        idle(); idle();
        chk("lu_add_wb_regwrite", 32'(bus.wb_regwrite), 32'd1);
        chk("lu_add_wb_rd",       32'(bus.wb_rd),       32'd6);

        // No stall: LUI ignores its rs fields; load into x0
        issue(1'b1, OP_LOAD, 5'd1, 5'd0, 5'd5, 1'b0);
        issue(1'b1, OP_LUI, 5'd5, 5'd5, 5'd5, 1'b0);
        chk("lui_no_stall", 32'(bus.pc_stall), 32'd0);
        issue(1'b1, OP_LOAD, 5'd1, 5'd0, 5'd0, 1'b0);
        issue(1'b1, OP_R, 5'd0, 5'd0, 5'd1, 1'b0);
        chk("x0_no_stall", 32'(bus.pc_stall), 32'd0);

        // Redirect beats load-use
        issue(1'b1, OP_LOAD, 5'd1, 5'd0, 5'd5, 1'b0);
        issue(1'b1, OP_R, 5'd5, 5'd1, 5'd6, 1'b1);
        chk("rd_flush",    32'(bus.ifid_flush), 32'd1);
        chk("rd_no_stall", 32'(bus.pc_stall),   32'd0);
        idle();
        chk("rd_ex_valid",    32'(bus.ex_valid),    32'd0);
        chk("rd_mem_memread", 32'(bus.mem_memread), 32'd1);

        // Redirect with an empty EX slot is ignored
        issue(1'b1, OP_R, 5'd1, 5'd2, 5'd9, 1'b1);
        chk("rd_ignored_flush", 32'(bus.ifid_flush), 32'd0);
        idle();
        chk("rd_ignored_ex_rd", 32'(bus.ex_rd), 32'd9);

        // All nine opcodes, rd=3
        issue(1'b1, OP_R,     5'd1, 5'd2, 5'd3, 1'b0);
        issue(1'b1, OP_I,     5'd1, 5'd2, 5'd3, 1'b0);
        issue(1'b1, OP_LOAD,  5'd1, 5'd2, 5'd3, 1'b0);
        issue(1'b1, OP_STORE, 5'd1, 5'd2, 5'd3, 1'b0);
        issue(1'b1, OP_BR,    5'd1, 5'd2, 5'd3, 1'b0);
        issue(1'b1, OP_JAL,   5'd1, 5'd2, 5'd3, 1'b0);
        chk("load_wb_memtoreg", 32'(bus.wb_memtoreg), 32'd1);
        issue(1'b1, OP_JALR,  5'd1, 5'd2, 5'd3, 1'b0);
        chk("jal_ex_aluop",      32'(bus.ex_aluop),    32'd3);
        chk("jal_ex_branch",     32'(bus.ex_branch),   32'd1);
        chk("store_wb_regwrite", 32'(bus.wb_regwrite), 32'd0);
        issue(1'b1, OP_LUI,   5'd1, 5'd2, 5'd3, 1'b0);
        chk("jalr_ex_jalrsel", 32'(bus.ex_jalrsel), 32'd1);
        chk("jalr_ex_alusrc",  32'(bus.ex_alusrc),  32'd1);
        issue(1'b1, OP_AUIPC, 5'd1, 5'd2, 5'd3, 1'b0);
        chk("lui_ex_aluop", 32'(bus.ex_aluop), 32'd3);
        chk("jal_wb_rwsel", 32'(bus.wb_rwsel), 32'd1);
        idle(); idle(); idle();
        chk("auipc_wb_rwsel",    32'(bus.wb_rwsel),    32'd3);
        chk("auipc_wb_regwrite", 32'(bus.wb_regwrite), 32'd1);
        chk("auipc_wb_rd",       32'(bus.wb_rd),       32'd3);

        // addi x0 never writes back
        issue(1'b1, OP_I, 5'd1, 5'd0, 5'd0, 1'b0);
        idle(); idle(); idle();
        chk("x0_wb_valid",    32'(bus.wb_valid),    32'd1);
        chk("x0_wb_regwrite", 32'(bus.wb_regwrite), 32'd0);

        // Illegal opcode and sticky flag
        issue(1'b1, OP_BAD, 5'd1, 5'd2, 5'd4, 1'b0);
        idle();
        chk("ill_ex_illegal", 32'(bus.ex_illegal),   32'd1);
        chk("ill_ex_aluop",   32'(bus.ex_aluop),     32'd0);
        chk("ill_ex_alusrc",  32'(bus.ex_alusrc),    32'd0);
        chk("ill_seen",       32'(bus.illegal_seen), 32'd1);
        idle(); idle(); idle();
        chk("ill_seen_sticky", 32'(bus.illegal_seen), 32'd1);
        chk("ill_ex_cleared",  32'(bus.ex_illegal),   32'd0);

        // Async reset mid-stall, no clock edge in between
        issue(1'b1, OP_LOAD, 5'd1, 5'd0, 5'd5, 1'b0);
        issue(1'b1, OP_R, 5'd5, 5'd1, 5'd6, 1'b0);
        chk("ar_pre_stall", 32'(bus.pc_stall), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("ar_pc_stall",     32'(bus.pc_stall),     32'd0);
        chk("ar_ifid_stall",   32'(bus.ifid_stall),   32'd0);
        chk("ar_ex_valid",     32'(bus.ex_valid),     32'd0);
        chk("ar_mem_valid",    32'(bus.mem_valid),    32'd0);
        chk("ar_illegal_seen", 32'(bus.illegal_seen), 32'd0);
        idle();
        rst_n = 1'b1;

        // First decode after release
        issue(1'b1, OP_LUI, 5'd0, 5'd0, 5'd7, 1'b0);
        idle();
        chk("post_rst_ex_rd",    32'(bus.ex_rd),    32'd7);
        chk("post_rst_ex_aluop", 32'(bus.ex_aluop), 32'd3);
        idle(); idle(); idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
